// File: rtl/m_wb_arbiter2.sv
// m_wb_arbiter2: two-master Wishbone arbiter in front of one shared slave.
//
// Grants the bus to one master at a time (IDLE / OWN0 / OWN1) with round-robin
// tie-break via lastgnt. The owner keeps the bus while its CYC_I stays high,
// and handoff to a waiting master happens with no dead cycle.
//
// Ports:
//   CLK_I, RST_I                    clock, synchronous active-high reset
//   mN_CYC_I/STB_I/WE_I             master N cycle, strobe, write enable (N=0,1)
//   mN_ADR_I/DAT_I/SEL_I            master N address, write data, byte select
//   mN_DAT_O/ACK_O/ERR_O            read data, acknowledge, bus error to master N
//   CYC_O/STB_O/WE_O/ADR_O/DAT_O/SEL_O  forwarded owner signals to the slave
//   DAT_I, ACK_I                    slave read data and acknowledge
//
// Optional feature: define WBARB_TIMEOUT_EN to add a TOWIDTH-bit timeout counter
// that terminates a stalled strobe with ERR_O to the owner.
module m_wb_arbiter2 #(
    parameter int TOWIDTH = 8
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        m0_CYC_I,
    input  logic        m0_STB_I,
    input  logic        m0_WE_I,
    input  logic [31:0] m0_ADR_I,
    input  logic [31:0] m0_DAT_I,
    input  logic [3:0]  m0_SEL_I,
    output logic [31:0] m0_DAT_O,
    output logic        m0_ACK_O,
    output logic        m0_ERR_O,
    input  logic        m1_CYC_I,
    input  logic        m1_STB_I,
    input  logic        m1_WE_I,
    input  logic [31:0] m1_ADR_I,
    input  logic [31:0] m1_DAT_I,
    input  logic [3:0]  m1_SEL_I,
    output logic [31:0] m1_DAT_O,
    output logic        m1_ACK_O,
    output logic        m1_ERR_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t r_state, w_next;
    logic   r_lastgnt;
    logic   w_own, w_sel1, w_to, w_ack;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_state   <= IDLE;
            r_lastgnt <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == OWN0 && !m0_CYC_I)
                r_lastgnt <= 1'b0;
            else if (r_state == OWN1 && !m1_CYC_I)
                r_lastgnt <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (m0_CYC_I && m1_CYC_I)
                    w_next = r_lastgnt ? OWN0 : OWN1;
                else if (m0_CYC_I)
                    w_next = OWN0;
                else if (m1_CYC_I)
                    w_next = OWN1;
            end
            OWN0:    if (!m0_CYC_I) w_next = m1_CYC_I ? OWN1 : IDLE;
            OWN1:    if (!m1_CYC_I) w_next = m0_CYC_I ? OWN0 : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Non-owner buses default to master 0 so IDLE presents master 0 values.
    assign w_own  = (r_state != IDLE);
    assign w_sel1 = (r_state == OWN1);

    assign CYC_O = w_own & (w_sel1 ? m1_CYC_I : m0_CYC_I);
    assign STB_O = w_own & (w_sel1 ? m1_STB_I : m0_STB_I);
    assign WE_O  = w_sel1 ? m1_WE_I  : m0_WE_I;
    assign ADR_O = w_sel1 ? m1_ADR_I : m0_ADR_I;
    assign DAT_O = w_sel1 ? m1_DAT_I : m0_DAT_I;
    assign SEL_O = w_sel1 ? m1_SEL_I : m0_SEL_I;

`ifdef WBARB_TIMEOUT_EN
    logic [TOWIDTH-1:0] r_cnt;

    // Timeout fires when the counter saturates; a late ACK that same cycle is dropped.
    assign w_to = w_own && (r_cnt == '1);

    always_ff @(posedge CLK_I) begin
        if (RST_I || ACK_I || w_to || (w_next != r_state))
            r_cnt <= '0;
        else if (STB_O)
            r_cnt <= r_cnt + TOWIDTH'(1);
    end
`else
    assign w_to = 1'b0;
`endif

    assign w_ack = ACK_I & ~w_to;

    assign m0_ACK_O = (r_state == OWN0) & w_ack & m0_CYC_I;
    assign m1_ACK_O = (r_state == OWN1) & w_ack & m1_CYC_I;
    assign m0_ERR_O = (r_state == OWN0) & w_to;
    assign m1_ERR_O = (r_state == OWN1) & w_to;

    assign m0_DAT_O = DAT_I;
    assign m1_DAT_O = DAT_I;
endmodule

// File: tb/tb_m_wb_arbiter2.sv
// tb_m_wb_arbiter2: directed scoreboard bench for the two-master Wishbone arbiter.
module tb_m_wb_arbiter2;
    localparam logic [31:0] A0 = 32'h0000_0004, A1 = 32'h0000_0100;
    localparam logic [31:0] D0 = 32'hD000_0000, D1 = 32'hD111_1111;
    localparam logic [3:0]  S0 = 4'hF, S1 = 4'h3;
`ifdef WBARB_TIMEOUT_EN
    localparam logic TO = 1'b1;
`else
    localparam logic TO = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic c0 = 0, s0 = 0, c1 = 0, s1 = 0, ack = 0;
    logic [31:0] dat_i = '0;
    logic [31:0] m0_dat_o, m1_dat_o, adr_o, dat_o;
    logic m0_ack, m0_err, m1_ack, m1_err, cyc_o, stb_o, we_o;
    logic [3:0] sel_o;

    always #5 clk = ~clk;

    m_wb_arbiter2 #(.TOWIDTH(4)) dut (
        .CLK_I(clk), .RST_I(rst),
        .m0_CYC_I(c0), .m0_STB_I(s0), .m0_WE_I(1'b0), .m0_ADR_I(A0), .m0_DAT_I(D0), .m0_SEL_I(S0),
        .m0_DAT_O(m0_dat_o), .m0_ACK_O(m0_ack), .m0_ERR_O(m0_err),
        .m1_CYC_I(c1), .m1_STB_I(s1), .m1_WE_I(1'b1), .m1_ADR_I(A1), .m1_DAT_I(D1), .m1_SEL_I(S1),
        .m1_DAT_O(m1_dat_o), .m1_ACK_O(m1_ack), .m1_ERR_O(m1_err),
        .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o), .ADR_O(adr_o), .DAT_O(dat_o), .SEL_O(sel_o),
        .DAT_I(dat_i), .ACK_I(ack)
    );

    typedef struct {
        string        name;
        logic [139:0] v;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    // Packed view: cyc, stb, we, adr, dat, sel, ack0, ack1, err0, err1, m0_dat, m1_dat
    task automatic step(input string nm, input logic r, i_c0, i_s0, i_c1, i_s1, i_ack,
                        input logic ecyc, estb, eown, ea0, ea1, ee0, ee1);
        exp_t e;
        logic [31:0] d;
        @(posedge clk);
        #1;
        d = $urandom;
        rst = r; c0 = i_c0; s0 = i_s0; c1 = i_c1; s1 = i_s1; ack = i_ack; dat_i = d;
        e.name = nm;
        e.v = {ecyc, estb, eown, eown ? A1 : A0, eown ? D1 : D0, eown ? S1 : S0,
               ea0, ea1, ee0, ee1, d, d};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [139:0] act;
            e = q.pop_front();
            act = {cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, m0_ack, m1_ack, m0_err, m1_err,
                   m0_dat_o, m1_dat_o};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s got %h exp %h", e.name, act, e.v);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        //          name         rst c0 s0 c1 s1 ak  cyc stb own a0 a1 e0 e1
        step("reset",         1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("req0_idle",     0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("grant0",        0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        step("ack0",          0, 1, 1, 0, 0, 1,  1, 1, 0, 1, 0, 0, 0);
        step("drop0",         0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("reset2",        1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("tie_idle",      0, 1, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        step("tie_m0",        0, 1, 1, 1, 1, 1,  1, 1, 0, 1, 0, 0, 0);
        step("m0_drop",       0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        step("m1_ack1",       0, 1, 1, 1, 1, 1,  1, 1, 1, 0, 1, 0, 0);
        step("m1_ack2",       0, 1, 1, 1, 1, 1,  1, 1, 1, 0, 1, 0, 0);
        step("m1_ack3",       0, 1, 1, 1, 1, 1,  1, 1, 1, 0, 1, 0, 0);
        step("m1_drop",       0, 1, 1, 0, 0, 1,  0, 0, 1, 0, 0, 0, 0);
        step("handoff0",      0, 1, 1, 1, 1, 0,  1, 1, 0, 0, 0, 0, 0);
        step("m0_drop2",      0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        step("own1",          0, 0, 0, 1, 1, 0,  1, 1, 1, 0, 0, 0, 0);
        step("m1_drop2",      0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 0);
        step("tie2_idle",     0, 1, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        step("tie2_m0",       0, 1, 1, 1, 1, 1,  1, 1, 0, 1, 0, 0, 0);
        step("rst_mid",       1, 1, 1, 0, 0, 1,  1, 1, 0, 1, 0, 0, 0);
        step("after_rst",     0, 1, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
        step("regrant",       0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 14; k++)
            step("to_wait",   0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        step("to_err",        0, 1, 1, 0, 0, 1,  1, 1, 0, !TO, 0, TO, 0);
        step("to_after",      0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        c0 = 0; s0 = 0; ack = 0;
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
